// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bus: MEM-side operation fields, the upstream stall, and the registered
// writeback outputs.
interface mem_wb_stage_if #(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 4
);
  logic                 mem_valid_in;
  logic                 mem_regwrite_in;
  logic [RF_ADDR_W-1:0] mem_rd_in;
  logic [1:0]           mem_memtoreg_in;
  logic                 mem_memread_in;
  logic                 mem_memwrite_in;
  logic [DATA_W-1:0]    mem_alu_in;
  logic [DATA_W-1:0]    mem_alu_src2_in;
  logic [DATA_W-1:0]    mem_link_in;
  logic                 mem_stall_out;
  logic                 wb_valid_out;
  logic                 wb_regwrite_out;
  logic [RF_ADDR_W-1:0] wb_rd_out;
  logic [DATA_W-1:0]    wb_regwrdata_out;
  logic                 wb_addr_err_out;

  modport master (
    output mem_valid_in, mem_regwrite_in, mem_rd_in, mem_memtoreg_in,
           mem_memread_in, mem_memwrite_in, mem_alu_in, mem_alu_src2_in, mem_link_in,
    input  mem_stall_out, wb_valid_out, wb_regwrite_out, wb_rd_out,
           wb_regwrdata_out, wb_addr_err_out
  );

  modport slave (
    input  mem_valid_in, mem_regwrite_in, mem_rd_in, mem_memtoreg_in,
           mem_memread_in, mem_memwrite_in, mem_alu_in, mem_alu_src2_in, mem_link_in,
    output mem_stall_out, wb_valid_out, wb_regwrite_out, wb_rd_out,
           wb_regwrdata_out, wb_addr_err_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: owns the data RAM, stalls upstream for multi-cycle loads
// and registers the selected writeback value into the MEM/WB register.
module mem_wb_stage #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2,
  parameter int RF_ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam bit MULTI = (RD_LAT > 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic [DATA_W-1:0] wb_mux(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] alu,
                                               input logic [DATA_W-1:0] mem,
                                               input logic [DATA_W-1:0] link);
    case (sel)
      2'b00:   return alu;
      2'b01:   return mem;
      2'b10:   return link;
      default: return '0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  ram_idx;
  logic              in_range, is_load, is_store, active;
  logic              multi_load, wait_done, ram_we, stall;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] ram [DEPTH];

  logic                 regwrite_p0, err_p0;
  logic [RF_ADDR_W-1:0] rd_p0;
  logic [1:0]           sel_p0;
  logic [DATA_W-1:0]    alu_p0, link_p0, mem_p0;

  logic                 wb_valid_p1, wb_regwrite_p1, wb_err_p1;
  logic [RF_ADDR_W-1:0] wb_rd_p1;
  logic [DATA_W-1:0]    wb_data_p1;

  assign addr     = ADDR_W'(bus.mem_alu_in);
  assign ram_idx  = IDX_W'(addr);
  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign active   = bus.mem_valid_in;
  assign is_store = bus.mem_memwrite_in;
  // A simultaneous read+write request is treated as a store.
  assign is_load  = bus.mem_memread_in & ~bus.mem_memwrite_in;

  assign multi_load = (state_q == S_IDLE) && active && is_load && MULTI;
  assign wait_done  = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
  assign ram_we     = rst_n && (state_q == S_IDLE) && active && is_store && in_range;
  assign ram_rd     = in_range ? ram[ram_idx] : '0;

  // FSM state register and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (multi_load)              cnt_q <= LAT_M1;
      else if (state_q == S_WAIT)  cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (multi_load) state_d = S_WAIT;
      S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE:  stall = multi_load;
        S_WAIT:  stall = (cnt_q > CNT_W'(1));
        default: stall = 1'b0;
      endcase
    end
  end

  // RAM write port; reads are write-first because the write lands before any later op reads
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.mem_alu_src2_in;
  end

  // p0: load operands captured at WAIT entry, never re-read from upstream
  always_ff @(posedge clk) begin
    if (multi_load) begin
      regwrite_p0 <= bus.mem_regwrite_in;
      rd_p0       <= bus.mem_rd_in;
      sel_p0      <= bus.mem_memtoreg_in;
      alu_p0      <= bus.mem_alu_in;
      link_p0     <= bus.mem_link_in;
      mem_p0      <= ram_rd;
      err_p0      <= ~in_range;
    end
  end

  // p1: MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_p1    <= 1'b0;
      wb_regwrite_p1 <= 1'b0;
      wb_rd_p1       <= '0;
      wb_data_p1     <= '0;
      wb_err_p1      <= 1'b0;
    end else if (wait_done) begin
      wb_valid_p1    <= 1'b1;
      wb_regwrite_p1 <= regwrite_p0;
      wb_rd_p1       <= rd_p0;
      wb_data_p1     <= wb_mux(sel_p0, alu_p0, mem_p0, link_p0);
      wb_err_p1      <= err_p0;
    end else if ((state_q == S_IDLE) && active && !multi_load) begin
      wb_valid_p1    <= 1'b1;
      wb_regwrite_p1 <= bus.mem_regwrite_in;
      wb_rd_p1       <= bus.mem_rd_in;
      wb_data_p1     <= wb_mux(bus.mem_memtoreg_in, bus.mem_alu_in, ram_rd, bus.mem_link_in);
      wb_err_p1      <= ~in_range & (is_load | is_store);
    end else begin
      wb_valid_p1    <= 1'b0;
      wb_regwrite_p1 <= 1'b0;
      wb_err_p1      <= 1'b0;
    end
  end

  assign bus.mem_stall_out    = stall;
  assign bus.wb_valid_out     = wb_valid_p1;
  assign bus.wb_regwrite_out  = wb_regwrite_p1;
  assign bus.wb_rd_out        = wb_rd_p1;
  assign bus.wb_regwrdata_out = wb_data_p1;
  assign bus.wb_addr_err_out  = wb_err_p1;

endmodule
